// File: rtl/grom_mem_arbiter.sv
//------------------------------------------------------------------------------
// grom_mem_arbiter: two-master req/gnt arbiter in front of the single-port RAM.
// Fixed priority to master 0; optional macro GROM_ARB_FAIR_EN adds a wait
// counter that forces master 1 through after MAX_WAIT refused cycles.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module grom_mem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  logic force_m1;

`ifdef GROM_ARB_FAIR_EN
  logic [3:0] wait_q, wait_d;

  // Master 1 has been refused MAX_WAIT times in a row: it wins this cycle.
  assign force_m1 = m1_req && (wait_q == 4'(MAX_WAIT));

  always_comb begin
    wait_d = wait_q;
    if (!m1_req || m1_gnt) begin
      wait_d = '0;
    end else begin
      wait_d = wait_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign force_m1 = 1'b0;
`endif

  assign m0_gnt = reset_n && m0_req && !force_m1;
  assign m1_gnt = reset_n && m1_req && (!m0_req || force_m1);

  logic              any_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign any_gnt = m0_gnt || m1_gnt;

  always_comb begin
    sel_we    = m0_we;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    if (m1_gnt) begin
      sel_we    = m1_we;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end
  end

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_owner_q, s1_owner_d;
  logic              s2_valid_q;
  logic              s2_owner_q;

  // Address/data hold their last values on idle cycles; only we/busy drop.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    busy_d      = any_gnt;
    s1_valid_d  = any_gnt && !sel_we;
    s1_owner_d  = m1_gnt;
    if (any_gnt) begin
      mem_addr_d  = sel_addr;
      mem_wdata_d = sel_wdata;
      mem_we_d    = sel_we;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_owner_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_owner_q  <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      s1_valid_q  <= s1_valid_d;
      s1_owner_q  <= s1_owner_d;
      s2_valid_q  <= s1_valid_q;
      s2_owner_q  <= s1_owner_q;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign busy      = busy_q;

  // Stage 2 lines up with the RAM's registered read data.
  assign m0_rvalid = s2_valid_q && !s2_owner_q;
  assign m1_rvalid = s2_valid_q && s2_owner_q;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_grom_mem_arbiter.sv
// Self-checking bench for grom_mem_arbiter with a behavioural RAM and model.
`default_nettype none

module tb_grom_mem_arbiter;

  localparam int MAX_WAIT = 4;
`ifdef GROM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [11:0] m0_addr = '0;
  logic [7:0]  m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [11:0] m1_addr = '0;
  logic [7:0]  m1_wdata = '0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [7:0]  m0_rdata, m1_rdata;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_we, busy;

  grom_mem_arbiter #(.ADDR_W(12), .DATA_W(8), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Single-port RAM with registered read
  logic [7:0] ram [0:4095];
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  typedef struct {
    int         due;
    logic       owner;
    logic [7:0] data;
  } ret_t;
  ret_t       rq[$];
  logic [7:0] ref_mem [0:4095];
  int         cyc, starve;
  logic       n_mwe, n_busy;
  logic [11:0] n_maddr;
  logic [7:0]  n_mwdata;
  logic        e_g0, e_g1, e_rv0, e_rv1, e_mwe, e_busy;
  logic [11:0] e_maddr;
  logic [7:0]  e_mwdata, e_rd;

  task automatic model_reset();
    rq.delete();
    cyc = 0; starve = 0;
    n_mwe = 1'b0; n_busy = 1'b0; n_maddr = '0; n_mwdata = '0;
  endtask

  // One call per cycle, at the sampling point, with the current inputs.
  task automatic model_eval();
    logic g0, g1, we;
    logic [11:0] a;
    logic [7:0] d;
    ret_t r;
    e_mwe = n_mwe; e_busy = n_busy; e_maddr = n_maddr; e_mwdata = n_mwdata;
    g1 = m1_req && (!m0_req || (FAIR && starve >= MAX_WAIT));
    g0 = m0_req && !g1;
    if (m1_req && !g1) starve++; else starve = 0;
    e_rv0 = 1'b0; e_rv1 = 1'b0; e_rd = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      if (r.owner) e_rv1 = 1'b1; else e_rv0 = 1'b1;
      e_rd = r.data;
    end
    if (g0 || g1) begin
      we = g1 ? m1_we : m0_we;
      a  = g1 ? m1_addr : m0_addr;
      d  = g1 ? m1_wdata : m0_wdata;
      n_mwe = we; n_busy = 1'b1; n_maddr = a; n_mwdata = d;
      if (we) ref_mem[a] = d;
      else begin
        r.due = cyc + 2; r.owner = g1; r.data = ref_mem[a];
        rq.push_back(r);
      end
    end else begin
      n_mwe = 1'b0; n_busy = 1'b0;
    end
    e_g0 = g0; e_g1 = g1;
    cyc++;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    next_cycle(); next_cycle();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; m0_req = 1'b1; m1_req = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we, busy} !== 6'b0) begin
      errors++; $display("FAIL reset_ctl got=%b exp=000000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we, busy});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 20'h0) begin
      errors++; $display("FAIL reset_mem got=%h exp=00000", {mem_addr, mem_wdata});
    end
    next_cycle();
    m0_req = 1'b0; m1_req = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_write_read();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 12'h123; m0_wdata = 8'hA5;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      errors++; $display("FAIL wr_gnt got=%b%b exp=10", m0_gnt, m1_gnt);
    end
    next_cycle();
    m0_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({m0_gnt, mem_we, busy} !== 3'b111 || mem_addr !== 12'h123 || mem_wdata !== 8'hA5) begin
      errors++; $display("FAIL wr_access got gnt=%b we=%b busy=%b addr=%h wd=%h exp 1 1 1 123 a5",
                         m0_gnt, mem_we, busy, mem_addr, mem_wdata);
    end
    next_cycle();
    m0_req = 1'b0;
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL rd_access got rv=%b we=%b busy=%b exp 0 0 1", m0_rvalid, mem_we, busy);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_rdata !== 8'hA5) begin
      errors++; $display("FAIL rd_return got rv0=%b rv1=%b data=%h exp 1 0 a5", m0_rvalid, m1_rvalid, m0_rdata);
    end
    next_cycle();
  endtask

  task automatic test_contention();
    logic exp1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'h200;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 12'h300;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      exp1 = FAIR && (k % (MAX_WAIT + 1) == MAX_WAIT);
      checks++;
      if (m0_gnt !== !exp1 || m1_gnt !== exp1) begin
        errors++; $display("FAIL contend k=%0d got=%b%b exp=%b%b", k, m0_gnt, m1_gnt, !exp1, exp1);
      end
      next_cycle();
    end
    m0_req = 1'b0;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b0 || m1_gnt !== 1'b1) begin
      errors++; $display("FAIL m0_drop got=%b%b exp=01", m0_gnt, m1_gnt);
    end
    next_cycle();
    m1_req = 1'b0;
    next_cycle(); next_cycle(); next_cycle();
  endtask

  task automatic test_interleave();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 12'h001; m0_wdata = 8'h11;
    next_cycle();
    m0_addr = 12'h002; m0_wdata = 8'h22;
    next_cycle();
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 12'h001;
    @(negedge clk);
    checks++;
    if (m1_gnt !== 1'b1) begin
      errors++; $display("FAIL il_m1_gnt got=%b exp=1", m1_gnt);
    end
    next_cycle();
    m1_req = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'h002;
    next_cycle();
    m0_req = 1'b0;
    @(negedge clk);
    checks++;
    if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0 || m1_rdata !== 8'h11) begin
      errors++; $display("FAIL il_first got rv1=%b rv0=%b d=%h exp 1 0 11", m1_rvalid, m0_rvalid, m1_rdata);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_rdata !== 8'h22) begin
      errors++; $display("FAIL il_second got rv0=%b rv1=%b d=%h exp 1 0 22", m0_rvalid, m1_rvalid, m0_rdata);
    end
    next_cycle();
  endtask

  task automatic test_idle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 12'h002) begin
        errors++; $display("FAIL idle k=%0d got busy=%b we=%b addr=%h exp 0 0 002", k, busy, mem_we, mem_addr);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'h010;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1) begin
      errors++; $display("FAIL rm_gnt got=%b exp=1", m0_gnt);
    end
    next_cycle();
    reset_n = 1'b0; m1_req = 1'b1;
    #1;
    checks++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we, busy} !== 6'b0 || {mem_addr, mem_wdata} !== 20'h0) begin
      errors++; $display("FAIL rm_async got ctl=%b mem=%h exp 0", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we, busy}, {mem_addr, mem_wdata});
    end
    next_cycle();
    reset_n = 1'b1; m1_req = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 12'h050; m0_wdata = 8'h3C;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1) begin
      errors++; $display("FAIL rm_first_gnt got=%b exp=1", m0_gnt);
    end
    next_cycle();
    m0_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
        errors++; $display("FAIL rm_no_rvalid k=%0d got=%b%b exp=00", k, m0_rvalid, m1_rvalid);
      end
      if (k == 0) begin
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 12'h050 || mem_wdata !== 8'h3C) begin
          errors++; $display("FAIL rm_write got we=%b a=%h d=%h exp 1 050 3c", mem_we, mem_addr, mem_wdata);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    logic pg0, pg1;
    do_reset();
    model_reset();
    for (int i = 0; i < 4096; i++) ref_mem[i] = ram[i];
    pg0 = 1'b0; pg1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!m0_req || pg0) begin
        m0_req = ($urandom_range(0, 9) < 7);
        m0_we = 1'($urandom_range(0, 1)); m0_addr = 12'($urandom_range(0, 15));
        m0_wdata = 8'($urandom);
      end
      if (!m1_req || pg1) begin
        m1_req = ($urandom_range(0, 9) < 6);
        m1_we = 1'($urandom_range(0, 1)); m1_addr = 12'($urandom_range(0, 15));
        m1_wdata = 8'($urandom);
      end
      @(negedge clk);
      model_eval();
      checks++;
      if (m0_gnt !== e_g0 || m1_gnt !== e_g1) begin
        errors++; $display("FAIL rnd_gnt c=%0d got=%b%b exp=%b%b", c, m0_gnt, m1_gnt, e_g0, e_g1);
      end
      checks++;
      if (mem_we !== e_mwe || busy !== e_busy || mem_addr !== e_maddr || mem_wdata !== e_mwdata) begin
        errors++; $display("FAIL rnd_mem c=%0d got we=%b busy=%b a=%h d=%h exp %b %b %h %h",
                           c, mem_we, busy, mem_addr, mem_wdata, e_mwe, e_busy, e_maddr, e_mwdata);
      end
      checks++;
      if (m0_rvalid !== e_rv0 || m1_rvalid !== e_rv1) begin
        errors++; $display("FAIL rnd_rvalid c=%0d got=%b%b exp=%b%b", c, m0_rvalid, m1_rvalid, e_rv0, e_rv1);
      end
      if (e_rv0 || e_rv1) begin
        checks++;
        if ((e_rv0 ? m0_rdata : m1_rdata) !== e_rd) begin
          errors++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, e_rv0 ? m0_rdata : m1_rdata, e_rd);
        end
      end
      pg0 = e_g0; pg1 = e_g1;
      next_cycle();
    end
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_contention();
    test_interleave();
    test_idle();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
